// File: rtl/imem_responder_if.sv
// ============================================================================
// imem_responder_if : fetch request / response handshake bundle.  Rev 1.0
// ============================================================================
`default_nettype none

interface imem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_instr_o;
  logic [31:0] rsp_addr_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_instr_o, rsp_addr_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_instr_o, rsp_addr_o, rsp_err_o
  );
endinterface

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
// imem_responder : word array behind a fixed-latency read pipe and FWFT FIFO.
// Optional access-fault trapping via IMEM_ERR_TRAP_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   PCrst_i,
  imem_responder_if.slave        bus,
  input  logic                   flush_i,
  input  logic                   prog_we_i,
  input  logic [31:0]            prog_addr_i,
  input  logic [31:0]            prog_data_i
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int          CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [31:0]        pipe_addr_q [LATENCY];
  logic [31:0]        pipe_addr_d [LATENCY];
  logic [31:0]        pipe_data_q [LATENCY];
  logic [31:0]        pipe_data_d [LATENCY];
  logic [LATENCY-1:0] pipe_err_q, pipe_err_d;

  logic [31:0]        fifo_instr_q [FIFO_DEPTH];
  logic [31:0]        fifo_addr_q  [FIFO_DEPTH];
  logic               fifo_err_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]   credit_q, credit_d;

  logic               req_ready;
  logic               rsp_valid;
  logic               accept;
  logic               push;
  logic               pop;
  logic               req_err;
  logic               wr_en;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [31:0]        rd_data;

  assign rd_idx = bus.req_addr_i[IDX_W+1:2];
  assign wr_idx = prog_addr_i[IDX_W+1:2];

`ifdef IMEM_ERR_TRAP_EN
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic unused_prog_lsb;
  assign unused_prog_lsb = ^prog_addr_i[1:0];

  assign req_err = (bus.req_addr_i[1:0] != 2'b00) |
                   ({1'b0, bus.req_addr_i} >= BYTE_LIMIT);
  assign wr_en   = prog_we_i & ({1'b0, prog_addr_i} < BYTE_LIMIT);
`else
  // Upper and byte-offset bits are don't-care: addresses wrap on the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr_i[31:IDX_W+2], bus.req_addr_i[1:0],
                              prog_addr_i[31:IDX_W+2], prog_addr_i[1:0]};

  assign req_err = 1'b0;
  assign wr_en   = prog_we_i;
`endif

  assign rd_data   = req_err ? NOP : mem_q[rd_idx];

  assign req_ready = (credit_q < CNT_W'(FIFO_DEPTH));
  assign rsp_valid = (fifo_cnt_q != '0);
  assign accept    = bus.req_valid_i & req_ready;
  assign push      = pipe_vld_q[LATENCY-1] & ~flush_i;
  assign pop       = rsp_valid & bus.rsp_ready_i & ~flush_i;

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_instr_o = rsp_valid ? fifo_instr_q[rd_ptr_q] : NOP;
  assign bus.rsp_addr_o  = rsp_valid ? fifo_addr_q[rd_ptr_q]  : 32'h0;
  assign bus.rsp_err_o   = rsp_valid ? fifo_err_q[rd_ptr_q]   : 1'b0;

  // Array write lands at the edge, so a same-cycle read captures old data.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= prog_data_i;
    end
  end

  // Stage 0 takes the accepted request even under flush; older stages die.
  always_comb begin
    pipe_vld_d  = pipe_vld_q;
    pipe_addr_d = pipe_addr_q;
    pipe_data_d = pipe_data_q;
    pipe_err_d  = pipe_err_q;
    for (int s = LATENCY - 1; s > 0; s--) begin
      pipe_vld_d[s]  = pipe_vld_q[s-1] & ~flush_i;
      pipe_addr_d[s] = pipe_addr_q[s-1];
      pipe_data_d[s] = pipe_data_q[s-1];
      pipe_err_d[s]  = pipe_err_q[s-1];
    end
    pipe_vld_d[0]  = accept;
    pipe_addr_d[0] = bus.req_addr_i;
    pipe_data_d[0] = rd_data;
    pipe_err_d[0]  = req_err;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    credit_d   = credit_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
      credit_d   = CNT_W'(accept);
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      credit_d   = credit_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        pipe_addr_q[s] <= '0;
        pipe_data_q[s] <= NOP;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      credit_q   <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
      pipe_data_q <= pipe_data_d;
      pipe_err_q  <= pipe_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      credit_q    <= credit_d;
    end
  end

  // Credits guarantee a free slot whenever the pipe exit is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
      fifo_addr_q[wr_ptr_q]  <= pipe_addr_q[LATENCY-1];
      fifo_err_q[wr_ptr_q]   <= pipe_err_q[LATENCY-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// tb_imem_responder : directed + random stimulus against a queue-based model.
// ============================================================================
`default_nettype none

module tb_imem_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          FD    = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        PCrst_i;
  logic        flush_i;
  logic        prog_we_i;
  logic [31:0] prog_addr_i;
  logic [31:0] prog_data_i;

  imem_responder_if bus ();

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk_i       (clk),
    .PCrst_i     (PCrst_i),
    .bus         (bus),
    .flush_i     (flush_i),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] mmem [DEPTH];
  exp_t        exp_q [$];

  function automatic bit m_err(input logic [31:0] a);
`ifdef IMEM_ERR_TRAP_EN
    return (a % 4 != 0) || (longint'(a) >= 4 * longint'(DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_wr_ok(input logic [31:0] a);
`ifdef IMEM_ERR_TRAP_EN
    return longint'(a) < 4 * longint'(DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive, compare outputs with the model, advance model at the edge.
  task automatic cycle(input bit v, input logic [31:0] a, input bit rr, input bit fl,
                       input bit we, input logic [31:0] wa, input logic [31:0] wd);
    bit   m_ready, m_vis, acc, pop;
    exp_t e;
    bus.req_valid_i = v;
    bus.req_addr_i  = a;
    bus.rsp_ready_i = rr;
    flush_i         = fl;
    prog_we_i       = we;
    prog_addr_i     = wa;
    prog_data_i     = wd;
    m_ready = (exp_q.size() < FD);
    m_vis   = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    check("req_ready", {31'b0, bus.req_ready_o}, {31'b0, m_ready});
    check("rsp_valid", {31'b0, bus.rsp_valid_o}, {31'b0, m_vis});
    if (m_vis) begin
      check("rsp_instr", bus.rsp_instr_o, exp_q[0].data);
      check("rsp_addr",  bus.rsp_addr_o,  exp_q[0].addr);
      check("rsp_err",   {31'b0, bus.rsp_err_o}, {31'b0, exp_q[0].err});
    end
    acc = v && m_ready;
    pop = m_vis && rr && !fl;
    e   = '0;
    if (acc) begin
      e.addr = a;
      e.err  = m_err(a);
      e.data = e.err ? NOP : mmem[m_idx(a)];
      e.due  = cyc + 1 + LAT;
    end
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(e);
    if (we && m_wr_ok(wa)) mmem[m_idx(wa)] = wd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle();
    check("drained_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("drained_ready", {31'b0, bus.req_ready_o}, 32'h1);
  endtask

  initial begin
    logic [31:0] a, wa;
    int          r;
    PCrst_i         = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.rsp_ready_i = 1'b0;
    flush_i         = 1'b0;
    prog_we_i       = 1'b0;
    prog_addr_i     = '0;
    prog_data_i     = '0;

    // Reset values
    @(negedge clk);
    check("rst_ready", {31'b0, bus.req_ready_o}, 32'h1);
    check("rst_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("rst_instr", bus.rsp_instr_o, NOP);
    check("rst_addr",  bus.rsp_addr_o,  32'h0);
    check("rst_err",   {31'b0, bus.rsp_err_o}, 32'h0);
    #2 PCrst_i = 1'b1;
    @(negedge clk);

    // Program load: words 0..7 fixed pattern, 8..63 random
    for (int i = 0; i < 64; i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'(i * 4),
            (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom);

    // Streaming 0..28 with consumer always ready
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();

    // Backpressure: only FD accepts, then release
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'(32 + i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();

    // Flush with a same-cycle accept of 0x40 while 3 are outstanding
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(16 + i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    drain();

    // Misaligned and out-of-range fetches
    cycle(1'b1, 32'h2,    1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();

    // Write/read collision on word 2, then re-read
    cycle(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    cycle(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      a = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      else if (r == 1) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(0, 63)) << 2;
      wa = ($urandom_range(0, 9) == 0) ? 32'h1000 + (32'($urandom_range(0, 3)) << 2)
                                       : 32'($urandom_range(0, 63)) << 2;
      cycle(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 5) == 0), wa, $urandom);
    end
    drain();

    // Asynchronous reset in the middle of a backpressured stream
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    #2 PCrst_i = 1'b0;
    #1;
    check("arst_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("arst_ready", {31'b0, bus.req_ready_o}, 32'h1);
    #1 PCrst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    cyc++;

    // Array contents survive reset
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
